// File: rtl/imem_arbiter_if.sv
// Bundle of CPU fetch, program-loader and instruction-RAM signals around imem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface imem_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 8
) ();
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_lock;
    logic          ld_gnt;
    logic          cpu_hold;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] stall_cnt;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_lock, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_data, ld_gnt, cpu_hold,
               mem_en, mem_we, mem_addr, mem_wdata, stall_cnt
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_lock, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_data, ld_gnt, cpu_hold,
               mem_en, mem_we, mem_addr, mem_wdata, stall_cnt
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the single-port instruction RAM between CPU fetch and
// the program loader, with a loader lock session and a saturating CPU stall counter.
module imem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           clb,
    imem_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] STALL_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r, state_s;
    logic          last_cpu_r;
    logic          fetch_gnt_r, ld_gnt_r, fetch_valid_r, cpu_hold_r;
    logic          mem_en_r, mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [CW-1:0] stall_cnt_r;
    logic          fetch_elig_s, ld_elig_s, grant_cpu_s, grant_ld_s, stall_s;

    // Grant decision and next state; a requester granted this cycle sits out this decision
    always_comb begin
        state_s      = state_r;
        grant_cpu_s  = 1'b0;
        grant_ld_s   = 1'b0;
        fetch_elig_s = bus.fetch_req & ~fetch_gnt_r;
        ld_elig_s    = bus.ld_req & ~ld_gnt_r;
        case (state_r)
            ST_ARB: begin
                if (fetch_elig_s && ld_elig_s) begin
                    grant_cpu_s = ~last_cpu_r;
                    grant_ld_s  = last_cpu_r;
                end else begin
                    grant_cpu_s = fetch_elig_s;
                    grant_ld_s  = ld_elig_s;
                end
                state_s = bus.ld_lock ? ST_LOCK : ST_ARB;
            end
            ST_LOCK: begin
                grant_ld_s = ld_elig_s;
                state_s    = bus.ld_lock ? ST_LOCK : ST_ARB;
            end
            default: begin
                state_s = ST_ARB;
            end
        endcase
        stall_s = fetch_elig_s & ~grant_cpu_s;
    end

    // Registered memory command, grant pulses, read-valid pipeline and stall counter
    always_ff @(posedge clk or posedge clb) begin
        if (clb) begin
            state_r       <= ST_ARB;
            last_cpu_r    <= 1'b0;
            fetch_gnt_r   <= 1'b0;
            ld_gnt_r      <= 1'b0;
            fetch_valid_r <= 1'b0;
            cpu_hold_r    <= 1'b0;
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {AW{1'b0}};
            mem_wdata_r   <= {DW{1'b0}};
            stall_cnt_r   <= {CW{1'b0}};
        end else begin
            state_r       <= state_s;
            fetch_gnt_r   <= grant_cpu_s;
            ld_gnt_r      <= grant_ld_s;
            fetch_valid_r <= fetch_gnt_r;
            cpu_hold_r    <= (state_s == ST_LOCK);
            mem_en_r      <= grant_cpu_s | grant_ld_s;
            mem_we_r      <= grant_ld_s;
            if (grant_ld_s) begin
                mem_addr_r  <= bus.ld_addr;
                mem_wdata_r <= bus.ld_wdata;
            end else if (grant_cpu_s) begin
                mem_addr_r  <= bus.fetch_addr;
                mem_wdata_r <= {DW{1'b0}};
            end else begin
                mem_wdata_r <= {DW{1'b0}};
            end
            if (grant_cpu_s) begin
                last_cpu_r <= 1'b1;
            end else if (grant_ld_s) begin
                last_cpu_r <= 1'b0;
            end
            if (stall_s && (stall_cnt_r != STALL_MAX)) begin
                stall_cnt_r <= stall_cnt_r + STALL_ONE;
            end
        end
    end

    // RAM data arrives one cycle after the grant pulse, so it is forwarded unregistered
    assign bus.fetch_data  = fetch_valid_r ? bus.mem_rdata : {DW{1'b0}};
    assign bus.fetch_valid = fetch_valid_r;
    assign bus.fetch_gnt   = fetch_gnt_r;
    assign bus.ld_gnt      = ld_gnt_r;
    assign bus.cpu_hold    = cpu_hold_r;
    assign bus.mem_en      = mem_en_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam logic [CW-1:0] STALL_MAX = 4'd15;

    logic clk = 1'b0;
    logic clb = 1'b1;
    int   total = 0;
    int   bad   = 0;

    imem_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    imem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk (clk),
        .clb (clb),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM driven by the DUT
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Reference model state: expected outputs of the current cycle
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          exp_fgnt, exp_lgnt, exp_hold, exp_en, exp_we, exp_fvalid, m_cpu_last;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_fdata, rd_hold;
    logic [CW-1:0] exp_stall;

    // Stimulus controls
    bit            cpu_on, ld_on, rnd_drop, lock_rand;
    int            p_f, p_l;
    logic [AW-1:0] fq [$];
    logic [AW+DW-1:0] lq [$];
    logic [DW-1:0] obs_q [$];
    int            hold_gnts;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_fgnt = 1'b0; exp_lgnt = 1'b0; exp_hold = 1'b0; exp_en = 1'b0; exp_we = 1'b0;
        exp_fvalid = 1'b0; m_cpu_last = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_fdata = '0; rd_hold = '0; exp_stall = '0;
    endtask

    task automatic check_all();
        check_eq("fetch_gnt",   bus.fetch_gnt,   exp_fgnt);
        check_eq("ld_gnt",      bus.ld_gnt,      exp_lgnt);
        check_eq("cpu_hold",    bus.cpu_hold,    exp_hold);
        check_eq("mem_en",      bus.mem_en,      exp_en);
        check_eq("mem_we",      bus.mem_we,      exp_we);
        check_eq("mem_addr",    bus.mem_addr,    exp_addr);
        check_eq("mem_wdata",   bus.mem_wdata,   exp_wdata);
        check_eq("stall_cnt",   bus.stall_cnt,   exp_stall);
        check_eq("fetch_valid", bus.fetch_valid, exp_fvalid);
        if (exp_fvalid) check_eq("fetch_data", bus.fetch_data, exp_fdata);
        if (bus.fetch_valid) obs_q.push_back(bus.fetch_data);
        if (bus.cpu_hold && bus.fetch_gnt) hold_gnts++;
    endtask

    // Requesters: hold a request until its grant, then issue a fresh one or go idle
    task automatic drive();
        if (!bus.fetch_req || exp_fgnt) begin
            bus.fetch_req = 1'b0;
            if (cpu_on) begin
                if (fq.size() > 0) begin
                    bus.fetch_req  = 1'b1;
                    bus.fetch_addr = fq.pop_front();
                end else if (int'($urandom_range(0, 9)) < p_f) begin
                    bus.fetch_req  = 1'b1;
                    bus.fetch_addr = AW'($urandom);
                end
            end
        end else if (rnd_drop && $urandom_range(0, 19) == 0) begin
            bus.fetch_req = 1'b0;
        end
        if (!bus.ld_req || exp_lgnt) begin
            bus.ld_req = 1'b0;
            if (ld_on) begin
                if (lq.size() > 0) begin
                    bus.ld_req = 1'b1;
                    {bus.ld_addr, bus.ld_wdata} = lq.pop_front();
                end else if (int'($urandom_range(0, 9)) < p_l) begin
                    bus.ld_req   = 1'b1;
                    bus.ld_addr  = AW'($urandom);
                    bus.ld_wdata = DW'($urandom);
                end
            end
        end else if (rnd_drop && $urandom_range(0, 19) == 0) begin
            bus.ld_req = 1'b0;
        end
        if (lock_rand && $urandom_range(0, 11) == 0) bus.ld_lock = ~bus.ld_lock;
    endtask

    // Apply the arbitration rules to this cycle's inputs; result is next cycle's outputs
    task automatic predict();
        logic f_ok, l_ok, cpu_win, ld_win;
        f_ok = bus.fetch_req && !exp_fgnt;
        l_ok = bus.ld_req && !exp_lgnt;
        if (exp_hold)          cpu_win = 1'b0;
        else if (f_ok && l_ok) cpu_win = !m_cpu_last;
        else                   cpu_win = f_ok;
        ld_win = l_ok && !cpu_win;
        exp_fvalid = exp_fgnt;
        exp_fdata  = rd_hold;
        if (cpu_win) rd_hold = ref_mem[bus.fetch_addr];
        if (f_ok && !cpu_win && exp_stall != STALL_MAX) exp_stall = exp_stall + 4'd1;
        exp_en = cpu_win || ld_win;
        exp_we = ld_win;
        if (cpu_win)     exp_addr = bus.fetch_addr;
        else if (ld_win) exp_addr = bus.ld_addr;
        exp_wdata = ld_win ? bus.ld_wdata : 8'h00;
        if (ld_win) ref_mem[bus.ld_addr] = bus.ld_wdata;
        if (cpu_win)     m_cpu_last = 1'b1;
        else if (ld_win) m_cpu_last = 1'b0;
        exp_fgnt = cpu_win;
        exp_lgnt = ld_win;
        exp_hold = bus.ld_lock;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic go();
        drive();
        predict();
    endtask

    task automatic cyc();
        tick();
        go();
    endtask

    // Mid-cycle asynchronous reset with a fetch pending; caller issues go() afterwards
    task automatic async_reset();
        #3;
        clb = 1'b1;
        bus.fetch_req = 1'b1;
        #1;
        check_eq("rst_fetch_gnt",   bus.fetch_gnt,   0);
        check_eq("rst_ld_gnt",      bus.ld_gnt,      0);
        check_eq("rst_fetch_valid", bus.fetch_valid, 0);
        check_eq("rst_fetch_data",  bus.fetch_data,  0);
        check_eq("rst_cpu_hold",    bus.cpu_hold,    0);
        check_eq("rst_mem_en",      bus.mem_en,      0);
        check_eq("rst_mem_we",      bus.mem_we,      0);
        check_eq("rst_mem_addr",    bus.mem_addr,    0);
        check_eq("rst_mem_wdata",   bus.mem_wdata,   0);
        check_eq("rst_stall_cnt",   bus.stall_cnt,   0);
        model_reset();
        repeat (2) tick();
        bus.fetch_req = 1'b0;
        clb = 1'b0;
    endtask

    initial begin
        int en_cnt, we_cnt, held_cnt;
        bit found;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.ld_req = 1'b0; bus.ld_addr = '0;
        bus.ld_wdata = '0; bus.ld_lock = 1'b0; bus.mem_rdata = '0;
        cpu_on = 1'b0; ld_on = 1'b0; rnd_drop = 1'b0; lock_rand = 1'b0; p_f = 0; p_l = 0;
        hold_gnts = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = DW'($urandom);
            ref_mem[i] = ram[i];
        end
        model_reset();

        // Power-on reset, then first fetch from address 3
        repeat (2) @(posedge clk);
        #1;
        check_all();
        clb = 1'b0;
        fq = '{4'h3};
        cpu_on = 1'b1;
        go();
        tick();
        check_eq("first_gnt",  bus.fetch_gnt, 1);
        check_eq("first_addr", bus.mem_addr,  4'h3);
        go();
        tick();
        check_eq("first_valid", bus.fetch_valid, 1);
        check_eq("first_data",  bus.fetch_data,  ref_mem[3]);

        // CPU only: addresses 0,1,2
        fq = '{4'h0, 4'h1, 4'h2};
        go();
        repeat (8) cyc();
        check_eq("cpu_only_stall", bus.stall_cnt, 0);

        // Contention from reset: strict alternation, one access per cycle
        p_f = 10; p_l = 10; ld_on = 1'b1;
        async_reset();
        go();
        en_cnt = 0; we_cnt = 0;
        repeat (10) begin
            cyc();
            en_cnt += int'(bus.mem_en);
            we_cnt += int'(bus.mem_we);
        end
        check_eq("cont_busy",   en_cnt, 10);
        check_eq("cont_writes", we_cnt, 5);
        cpu_on = 1'b0; ld_on = 1'b0; p_f = 0; p_l = 0;
        repeat (4) cyc();

        // Lock session: three writes while the CPU is held with a fetch pending
        async_reset();
        bus.ld_lock = 1'b1;
        go();
        hold_gnts = 0;
        held_cnt = 0;
        fq = '{4'h9, 4'h0, 4'h1, 4'h2};
        lq = '{{4'h0, 8'hD1}, {4'h1, 8'h12}, {4'h2, 8'hF0}};
        cpu_on = 1'b1; ld_on = 1'b1;
        repeat (10) begin
            cyc();
            if (bus.fetch_req) held_cnt++;
        end
        tick();
        check_eq("lock_hold",    bus.cpu_hold,  1);
        check_eq("lock_no_fgnt", hold_gnts,     0);
        check_eq("lock_stall",   bus.stall_cnt, held_cnt);
        obs_q.delete();
        bus.ld_lock = 1'b0;
        ld_on = 1'b0;
        go();
        for (int i = 0; i < 20 && obs_q.size() < 4; i++) cyc();
        check_eq("lock_rd_cnt", obs_q.size(), 4);
        if (obs_q.size() >= 4) begin
            check_eq("lock_rd0", obs_q[1], 8'hD1);
            check_eq("lock_rd1", obs_q[2], 8'h12);
            check_eq("lock_rd2", obs_q[3], 8'hF0);
        end

        // Lock rising in the cycle a CPU grant is visible
        fq = '{4'h5};
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (exp_fgnt) begin
                found = 1'b1;
                bus.ld_lock = 1'b1;
            end
            go();
        end
        check_eq("inflight_seen", found, 1);
        tick();
        check_eq("inflight_valid", bus.fetch_valid, 1);
        check_eq("inflight_data",  bus.fetch_data,  ref_mem[5]);
        check_eq("inflight_hold",  bus.cpu_hold,    1);
        bus.ld_lock = 1'b0;
        go();
        repeat (3) cyc();

        // Stall counter saturation under lock
        async_reset();
        bus.ld_lock = 1'b1;
        go();
        tick();
        fq = '{4'h7};
        go();
        repeat (20) cyc();
        tick();
        check_eq("sat_stall", bus.stall_cnt, 4'd15);
        bus.ld_lock = 1'b0;
        go();
        repeat (4) cyc();

        // Randomized traffic with a mid-stream reset
        cpu_on = 1'b1; ld_on = 1'b1; p_f = 6; p_l = 4; rnd_drop = 1'b1; lock_rand = 1'b1;
        repeat (200) cyc();
        async_reset();
        go();
        repeat (200) cyc();
        tick();
        lock_rand = 1'b0; cpu_on = 1'b0; ld_on = 1'b0;
        bus.ld_lock = 1'b0;
        go();
        repeat (6) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
